// File: rtl/fifo_rd_pkg.sv
// Shared types for the fifo_burst_reader read engine.
// FIFO_RD_WIDTH sets the data width of the skid entry; it must match the FIFO width.
package fifo_rd_pkg;

    localparam int unsigned FIFO_RD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fifo_rd_state_e;

    typedef struct packed {
        logic [FIFO_RD_WIDTH-1:0] data;
        logic                     last;
    } fifo_rd_entry_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry register skid buffer: slot0 is always the head, slot1 holds the overflow word.
module fifo_rd_skid
    import fifo_rd_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  fifo_rd_entry_t push_entry_i,
    input  logic           pop_i,
    output logic [1:0]     count_o,
    output fifo_rd_entry_t head_o
);

    fifo_rd_entry_t slot0_q, slot0_d;
    fifo_rd_entry_t slot1_q, slot1_d;
    logic [1:0]     count_q, count_d;
    logic           pop_ok;
    logic           push_ok;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        pop_ok  = pop_i && (count_q != 2'd0);
        push_ok = push_i && ((count_q != 2'd2) || pop_ok);

        if (pop_ok) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end

        // Push lands in the first free slot after any pop has shifted the head.
        if (push_ok) begin
            if (count_d == 2'd0) begin
                slot0_d = push_entry_i;
            end else begin
                slot1_d = push_entry_i;
            end
            count_d = count_d + 2'd1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data slots are reset as well, so m_data reads 0 coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = slot0_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a framed burst of burst_len words from a show-ahead FIFO onto a valid/ready stream.
// Optional empty-FIFO abort is enabled with the FIFO_RD_TIMEOUT_EN macro.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned WIDTH   = FIFO_RD_WIDTH,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             fifo_ren,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready
);

    fifo_rd_state_e   state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [1:0]       skid_count;
    fifo_rd_entry_t   push_entry;
    fifo_rd_entry_t   skid_head;
    logic             pop_fire;
    logic             hs_fire;
    logic             start_ok;
    logic             timeout_hit;

    // Pop depends only on registered state and FIFO flags, never on m_ready.
    assign pop_fire = (state_q == READ) && !fifo_empty && (skid_count < 2'd2)
                      && (remaining_q != '0);
    assign hs_fire  = m_valid && m_ready;
    assign start_ok = (state_q == IDLE) && start;

    always_comb begin
        push_entry      = '0;
        push_entry.data = fifo_data;
        push_entry.last = (remaining_q == LEN_W'(1));
    end

    fifo_rd_skid u_skid (
        .clk          (clk),
        .rst          (rst),
        .push_i       (pop_fire),
        .push_entry_i (push_entry),
        .pop_i        (hs_fire),
        .count_o      (skid_count),
        .head_o       (skid_head)
    );

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] empty_cnt_q, empty_cnt_d;
    logic            abort_q, abort_d;

    // Counts consecutive starved cycles in READ; any pop restarts the count.
    always_comb begin
        empty_cnt_d = empty_cnt_q;
        timeout_hit = 1'b0;
        if ((state_q != READ) || pop_fire) begin
            empty_cnt_d = '0;
        end else if (fifo_empty && (remaining_q != '0)) begin
            empty_cnt_d = empty_cnt_q + TO_W'(1);
            timeout_hit = (empty_cnt_d == TO_W'(TIMEOUT));
        end
    end

    always_comb begin
        abort_d = abort_q;
        if (start_ok) begin
            abort_d = 1'b0;
        end else if (timeout_hit) begin
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_cnt_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            empty_cnt_q <= empty_cnt_d;
            abort_q     <= abort_d;
        end
    end

    assign aborted = (state_q == DONE) && abort_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign aborted        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = burst_len;
                    state_d     = (burst_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (pop_fire) begin
                    remaining_d = remaining_q - LEN_W'(1);
                end
                if (timeout_hit) begin
                    remaining_d = '0;
                    state_d     = DRAIN;
                end else if (pop_fire && (remaining_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            // Leave once the skid buffer will be empty after this cycle's handshake.
            DRAIN: begin
                if ((skid_count == 2'd0) || ((skid_count == 2'd1) && hs_fire)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign fifo_ren = pop_fire;
    assign m_valid  = (skid_count != 2'd0);
    assign m_data   = skid_head.data;
    assign m_last   = skid_head.last;

endmodule
